// File: rtl/sample_window.sv
// Five-tap sample delay line with valid/ready handshake on both sides, feeding the smoothing FIR.
// Optional macro SAMPLE_WINDOW_ZERO_PAD_EN emits zero-padded windows from the first accepted sample.
module sample_window #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        fill
);

  localparam int unsigned NumTaps = 5;
  localparam logic [2:0]  FillMax = 3'd5;

  logic [DATA_W-1:0] taps_q [NumTaps];
  logic [DATA_W-1:0] taps_d [NumTaps];
  logic [2:0]        fill_q, fill_d;
  logic              out_valid_q, out_valid_d;

  logic       accept;
  logic [2:0] fill_inc;
  logic       qualify;

  // A window may be replaced in the same edge it is consumed, giving one window per clock.
  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign fill_inc = (fill_q >= FillMax) ? FillMax : fill_q + 3'd1;

`ifdef SAMPLE_WINDOW_ZERO_PAD_EN
  assign qualify = 1'b1;
`else
  assign qualify = (fill_inc == FillMax);
`endif

  always_comb begin
    taps_d      = taps_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      for (int i = 0; i < NumTaps; i++) begin
        taps_d[i] = '0;
      end
      fill_d      = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      for (int i = 1; i < NumTaps; i++) begin
        taps_d[i] = taps_q[i-1];
      end
      taps_d[0] = in_data;
      fill_d    = fill_inc;
      if (qualify) begin
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumTaps; i++) begin
        taps_q[i] <= '0;
      end
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumTaps; i++) begin
        taps_q[i] <= taps_d[i];
      end
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign win0      = taps_q[0];
  assign win1      = taps_q[1];
  assign win2      = taps_q[2];
  assign win3      = taps_q[3];
  assign win4      = taps_q[4];
  assign out_valid = out_valid_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_sample_window.sv
// Randomized and directed bench for sample_window against a queue-based window model.
module tb_sample_window;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, win0, win1, win2, win3, win4;
  logic [2:0] fill;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: accepted samples newest-first, plus the output-valid flag.
  logic [7:0] hist[$];
  logic       m_ov = 1'b0;

  sample_window #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win0      (win0),
    .win1      (win1),
    .win2      (win2),
    .win3      (win3),
    .win4      (win4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_tap(input int i);
    return (i < hist.size()) ? hist[i] : 8'd0;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check_eq("fill", {29'd0, fill}, hist.size());
    check_eq("win0", {24'd0, win0}, {24'd0, m_tap(0)});
    check_eq("win1", {24'd0, win1}, {24'd0, m_tap(1)});
    check_eq("win2", {24'd0, win2}, {24'd0, m_tap(2)});
    check_eq("win3", {24'd0, win3}, {24'd0, m_tap(3)});
    check_eq("win4", {24'd0, win4}, {24'd0, m_tap(4)});
  endtask

  // One clock cycle: drive, check ready, advance the model across the edge, check outputs.
  task automatic step(input logic vld, input logic [7:0] data, input logic ordy,
                      input logic fl, input logic rst);
    logic exp_ready, acc, qual;
    in_valid  = vld;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rst;
    #1;
    exp_ready = rst && !fl && (!m_ov || ordy);
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    acc = vld && exp_ready;
    @(posedge clk);
    if (!rst || fl) begin
      hist.delete();
      m_ov = 1'b0;
    end else if (acc) begin
      hist.push_front(data);
      if (hist.size() > 5) void'(hist.pop_back());
`ifdef SAMPLE_WINDOW_ZERO_PAD_EN
      qual = 1'b1;
`else
      qual = (hist.size() == 5);
`endif
      if (qual) m_ov = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset for two cycles.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);

    // Fill with 1..5.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    check_eq("fill5_valid", {31'd0, out_valid}, 32'd1);
    check_eq("fill5_win", {win0, win1, win2, win3}, 32'h05040302);
    check_eq("fill5_win4", {24'd0, win4}, 32'd1);

    // Continuous feed 10..20.
    for (int i = 10; i <= 20; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    check_eq("feed_win", {win0, win1, win2, win3}, 32'h14131211);
    check_eq("feed_win4", {24'd0, win4}, 32'h10);
    check_eq("feed_fill", {29'd0, fill}, 32'd5);

    // Stall for three cycles with a pending sample, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 8'd21, 1'b0, 1'b0, 1'b1);
    check_eq("stall_win0", {24'd0, win0}, 32'd20);
    step(1'b1, 8'd21, 1'b1, 1'b0, 1'b1);
    check_eq("release_win", {16'd0, win0, win1}, 32'h1514);
    step(1'b1, 8'd22, 1'b1, 1'b0, 1'b1);

    // Flush with a sample presented.
    step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
    check_eq("flush_fill", {29'd0, fill}, 32'd0);
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i + 40), 1'b1, 1'b0, 1'b1);

    // Mid-stream reset, then refill.
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i + 60), 1'b1, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 39) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
